// File: rtl/aes_pkg.sv
// Shared AES constants, key-schedule FSM encodings and byte/word helpers.
package aes_pkg;

  localparam logic        AES_128_BIT_KEY = 1'b0;
  localparam logic        AES_256_BIT_KEY = 1'b1;
  localparam int unsigned AES128_ROUNDS   = 10;
  localparam int unsigned AES256_ROUNDS   = 14;
  localparam int unsigned NUM_RK          = AES256_ROUNDS + 1;
  localparam int unsigned WORD_W          = 32;
  localparam int unsigned BLOCK_W         = 128;
  localparam int unsigned KEY_W           = 256;
  localparam int unsigned CTR_W           = 4;

  typedef enum logic [1:0] {
    KEY_IDLE = 2'd0,
    KEY_INIT = 2'd1,
    KEY_GEN  = 2'd2
  } key_state_t;

  // One round key; w0 occupies the most significant word.
  typedef struct packed {
    logic [WORD_W-1:0] w0;
    logic [WORD_W-1:0] w1;
    logic [WORD_W-1:0] w2;
    logic [WORD_W-1:0] w3;
  } round_key_t;

  // GF(2^8) doubling modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Left byte rotate of a word.
  function automatic logic [WORD_W-1:0] rotword(input logic [WORD_W-1:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_mem.sv
// Iterative AES-128/256 key expansion with a 15-entry round-key store and
// a combinational read port for the encipher block.
module aes_key_mem
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               init,
  input  logic [KEY_W-1:0]   key,
  input  logic               keylen,
  input  logic [CTR_W-1:0]   round,
  output logic [BLOCK_W-1:0] round_key,
  output logic               ready,
  output logic [WORD_W-1:0]  sboxw,
  input  logic [WORD_W-1:0]  new_sboxw
);

  key_state_t       state;
  key_state_t       state_next;
  round_key_t       rk [NUM_RK];
  logic [7:0]       rcon;
  logic [CTR_W-1:0] ctr;
  logic             keylen_q;

  logic             latch_keylen;
  logic             load_key;
  logic             gen_step;
  logic             set_ready;
  logic             gen_last;
  logic [CTR_W-1:0] last_round;
  logic [CTR_W-1:0] p_idx;
  logic [CTR_W-1:0] q_idx;
  round_key_t       p;
  round_key_t       q;
  round_key_t       new_rk;
  logic             use_rcon;
  logic [WORD_W-1:0] t;

  // Final generated index for the latched key length.
  always_comb begin
    last_round = keylen_q ? CTR_W'(AES256_ROUNDS) : CTR_W'(AES128_ROUNDS);
    gen_last   = (ctr == last_round);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= KEY_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic; init is only honoured in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      KEY_IDLE: if (init) state_next = KEY_INIT;
      KEY_INIT: state_next = KEY_GEN;
      KEY_GEN:  if (gen_last) state_next = KEY_IDLE;
      default:  state_next = KEY_IDLE;
    endcase
  end

  // FSM output decode into datapath strobes.
  always_comb begin
    latch_keylen = 1'b0;
    load_key     = 1'b0;
    gen_step     = 1'b0;
    set_ready    = 1'b0;
    case (state)
      KEY_IDLE: latch_keylen = init;
      KEY_INIT: load_key     = 1'b1;
      KEY_GEN: begin
        gen_step  = 1'b1;
        set_ready = gen_last;
      end
      default: ;
    endcase
  end

  // Next round-key computation from the previous one or two stored keys.
  always_comb begin
    p_idx    = (ctr == '0) ? '0 : ctr - CTR_W'(1);
    q_idx    = p_idx;
    if (keylen_q) begin
      q_idx  = (ctr < CTR_W'(2)) ? '0 : ctr - CTR_W'(2);
    end
    p        = rk[p_idx];
    q        = rk[q_idx];
    use_rcon = !keylen_q || !ctr[0];
    t        = use_rcon ? (rotword(new_sboxw) ^ {rcon, 24'h0}) : new_sboxw;
    new_rk.w0 = q.w0 ^ t;
    new_rk.w1 = q.w1 ^ new_rk.w0;
    new_rk.w2 = q.w2 ^ new_rk.w1;
    new_rk.w3 = q.w3 ^ new_rk.w2;
    sboxw    = (state == KEY_GEN) ? p.w3 : '0;
  end

  // Unregistered read port; out-of-range indices read as zero.
  always_comb begin
    round_key = (round < CTR_W'(NUM_RK)) ? rk[round] : '0;
  end

  // Round-key store, rcon and counter updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_RK); i++) begin
        rk[i] <= '0;
      end
      rcon     <= 8'h01;
      ctr      <= '0;
      keylen_q <= AES_128_BIT_KEY;
    end else begin
      if (latch_keylen) begin
        keylen_q <= keylen;
      end
      if (load_key) begin
        rk[0] <= round_key_t'(key[255:128]);
        if (keylen_q == AES_256_BIT_KEY) begin
          rk[1] <= round_key_t'(key[127:0]);
        end
        rcon <= 8'h01;
        ctr  <= keylen_q ? CTR_W'(2) : CTR_W'(1);
      end
      if (gen_step) begin
        rk[ctr] <= new_rk;
        ctr     <= ctr + CTR_W'(1);
        if (use_rcon) begin
          rcon <= xtime(rcon);
        end
      end
    end
  end

  // Ready flag: drops on accepted init, rises after the last key is written.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready <= 1'b1;
    end else if (latch_keylen) begin
      ready <= 1'b0;
    end else if (set_ready) begin
      ready <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_key_mem.sv
// Directed bench for aes_key_mem using FIPS-197 key-expansion vectors.
`timescale 1ns/1ps
module tb_aes_key_mem;

  logic         clk = 1'b0;
  logic         reset;
  logic         init;
  logic [255:0] key;
  logic         keylen;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic         ready;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0]   sbox_tab [256];
  logic [127:0] exp128 [11];

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KALT = 256'h00112233445566778899aabbccddeeff0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  aes_key_mem dut (
    .clk       (clk),
    .reset     (reset),
    .init      (init),
    .key       (key),
    .keylen    (keylen),
    .round     (round),
    .round_key (round_key),
    .ready     (ready),
    .sboxw     (sboxw),
    .new_sboxw (new_sboxw)
  );

  always #50 clk = ~clk;

  // External S-box: four byte lookups from a table built from GF(2^8) inversion.
  assign new_sboxw = {sbox_tab[sboxw[31:24]], sbox_tab[sboxw[23:16]],
                      sbox_tab[sboxw[15:8]],  sbox_tab[sboxw[7:0]]};

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] v);
    logic [7:0] inv = 8'h01;
    logic [7:0] s;
    for (int i = 0; i < 254; i++) inv = gmul(inv, v);
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
        {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reads every round index and checks the store is fully cleared.
  task automatic check_cleared();
    for (int r = 0; r < 16; r++) begin
      round = 4'(r);
      #1;
      check($sformatf("cleared_rk%0d", r), round_key, 128'h0);
    end
  endtask

  // Runs one expansion from the current cycle (cycle 0 = init driven).
  // mode 1: re-pulse init at cycle 5 with another key; mode 2: toggle keylen in GEN.
  task automatic expand(input logic [255:0] k, input logic kl, input int done_cyc,
                        input int mode);
    cyc    = 0;
    key    = k;
    keylen = kl;
    init   = 1'b1;
    for (int c = 1; c <= done_cyc; c++) begin
      tick();
      init = (mode == 1 && c == 5);
      if (mode == 1 && c == 5) key = KALT;
      if (mode == 2 && c >= 2) keylen = ~keylen;
      check("ready", 128'(ready), 128'(c >= done_cyc));
      if (kl == 1'b0 && c >= 2) begin
        round = 4'(c - 2);
        #1;
        check($sformatf("rk%0d_at_valid", c - 2), round_key, exp128[c - 2]);
      end
      if (kl == 1'b0 && c == 2) check("sboxw_gen1", 128'(sboxw), 128'(k[159:128]));
      if (c == done_cyc) check("sboxw_idle", 128'(sboxw), 128'h0);
    end
    init   = 1'b0;
    keylen = kl;
  endtask

  task automatic check_all128();
    for (int r = 0; r <= 10; r++) begin
      round = 4'(r);
      #1;
      check($sformatf("aes128_rk%0d", r), round_key, exp128[r]);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));
    exp128[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp128[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp128[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp128[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp128[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp128[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp128[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp128[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp128[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp128[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp128[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    reset  = 1'b1;
    init   = 1'b0;
    key    = '0;
    keylen = 1'b0;
    round  = '0;
    tick();
    tick();
    check("reset_ready", 128'(ready), 128'h1);
    check("reset_sboxw", 128'(sboxw), 128'h0);
    check_cleared();
    reset = 1'b0;
    tick();

    // Plain AES-128 expansion.
    expand(K128, 1'b0, 12, 0);
    check_all128();
    round = 4'd15;
    #1;
    check("round15_zero", round_key, 128'h0);

    // AES-256, then AES-128 init in the very cycle ready rises.
    tick();
    expand(K256, 1'b1, 15, 0);
    round = 4'd0;  #1; check("aes256_rk0",  round_key, K256[255:128]);
    round = 4'd1;  #1; check("aes256_rk1",  round_key, K256[127:0]);
    round = 4'd2;  #1; check("aes256_rk2",  round_key, 128'h9ba354118e6925afa51a8b5f2067fcde);
    round = 4'd14; #1; check("aes256_rk14", round_key, 128'hfe4890d1e6188d0b046df344706c631e);
    expand(K128, 1'b0, 12, 0);
    check_all128();

    // Re-init while busy is ignored.
    tick();
    expand(K128, 1'b0, 12, 1);
    check_all128();

    // keylen toggling during GEN has no effect; round 15 reads zero.
    tick();
    expand(K128, 1'b0, 12, 2);
    check_all128();
    round = 4'd15;
    #1;
    check("round15_zero_b", round_key, 128'h0);

    // Reset at cycle 6 of an expansion aborts to the reset state.
    tick();
    cyc    = 0;
    key    = K256;
    keylen = 1'b1;
    init   = 1'b1;
    tick();
    init = 1'b0;
    while (cyc < 6) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_ready", 128'(ready), 128'h1);
    check("abort_sboxw", 128'(sboxw), 128'h0);
    check_cleared();
    expand(K128, 1'b0, 12, 0);
    check_all128();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aes_key_mem.md
# aes_key_mem

Iterative AES key-expansion engine sitting directly upstream of the encipher round block. On `init` it latches a 128- or 256-bit cipher key, generates all round keys one per cycle and stores them. Afterwards it serves `round_key` combinationally for whatever round index the encipher block presents. The S-box used for SubWord is external: a 32-bit S-box word port driving four shared byte S-boxes.

## Interface
- No parameters; round counts are fixed constants in the shared package.
- `clk`  in  1  — single clock; all state updates on rising edge.
- `reset`  in  1  — synchronous, active-high reset.
- `init`  in  1  — start-expansion pulse; sampled only in IDLE.
- `key`  in  256  — cipher key; AES-128 uses `key[255:128]`.
- `keylen`  in  1  — 0 = AES-128 (10 rounds), 1 = AES-256 (14 rounds).
- `round`  in  4  — round index requested by the encipher block.
- `round_key`  out  128  — stored key for `round`; combinational read.
- `ready`  out  1  — high when idle with a complete key schedule.
- `sboxw`  out  32  — word sent to the external S-boxes.
- `new_sboxw`  in  32  — S-box result for `sboxw`, valid the same cycle.

## Operation
- Storage: 15 × 128-bit round-key registers `rk[0..14]`, an 8-bit `rcon` register, a 4-bit counter `ctr`, and latched `keylen_q`.
- FSM states and transitions:
  - IDLE → INIT when `init` is high. Latch `keylen`, set `ready` ← 0.
  - INIT:
    - Write `rk0` ← `key[255:128]`.
    - If `keylen_q` = 1, also write `rk1` ← `key[127:0]`.
    - Set `rcon` ← 0x01 and `ctr` ← 1 (AES-128) or 2 (AES-256).
    - Go to GEN.
  - GEN: write one key `rk[ctr]` per cycle, then increment `ctr`. When `ctr` equals the last round (10 or 14), set `ready` ← 1 and return to IDLE.
- Word generation. Let `p` = `rk[ctr-1]` and `q` = `rk[ctr-1]` for AES-128, or `rk[ctr-2]` for AES-256. Drive `sboxw` = `p.w3`; `sboxw` is 0 outside GEN.
- Temp value `t`:
  - AES-128, and AES-256 with `ctr` even: `t` = RotWord(`new_sboxw`) ^ {`rcon`, 24'h0}. RotWord is a left byte rotate; SubWord and RotWord commute.
  - AES-256 with `ctr` odd: `t` = `new_sboxw`.
- New key words: `w0` = `q.w0` ^ `t`; `w1` = `q.w1` ^ `w0`; `w2` = `q.w2` ^ `w1`; `w3` = `q.w3` ^ `w2`.
- `rcon` ← xtime(`rcon`) after each rcon-consuming step. xtime is a GF(2^8) doubling with polynomial 0x11b.
- Read port: `round_key` = `rk[round]`.
  - `round` > 14 returns 0.
  - Indices above the current key length return whatever is stored.
- Boundary rules:
  - `init` while busy (INIT or GEN) is ignored.
  - `key` is sampled in INIT; `keylen` is sampled on the IDLE→INIT edge. Later changes have no effect.
  - `init` re-issued in IDLE regenerates and overwrites all keys; `ready` drops for the full duration.
  - `round_key` is read freely while busy and returns partially updated contents. The consumer must start only when `ready` = 1.

## Timing
- Reset values: `ready` = 1, `round_key` = 0 (all `rk` cleared), `sboxw` = 0, state IDLE, `rcon` = 0x01, `ctr` = 0.
- Reset mid-expansion aborts immediately, with the same values as above.
- Define cycle 0 as the cycle in which `init` = 1 is sampled in IDLE:
  - `ready` = 0 from cycle 1.
  - `rk0` (and `rk1` for AES-256) is valid from cycle 2.
  - `rk[n]` is valid from cycle n+2.
  - AES-128: `ready` = 1 from cycle 12.
  - AES-256: `ready` = 1 from cycle 15.
- `round_key` has zero-cycle latency from `round`; there is no register on the read path.
- The S-box path is combinational within one GEN cycle.

## Structure
- Shared package `aes_pkg` holds:
  - constants `AES_128_BIT_KEY`/`AES_256_BIT_KEY`, `AES128_ROUNDS` = 10, `AES256_ROUNDS` = 14;
  - FSM state encodings (`KEY_IDLE`, `KEY_INIT`, `KEY_GEN`);
  - functions `xtime` and `rotword`.
- No sub-module inside the block. The top level wires `sboxw`/`new_sboxw` to a 4-byte `aes_sbox` instance.

## Test plan
- AES-128 FIPS-197 key 2b7e1516 28aed2a6 abf71588 09cf4f3c, `init` at cycle 0 → `ready` = 0 for cycles 1–11, 1 at cycle 12. Then `round`=1 → a0fafe17 88542cb1 23a33939 2a6c7605; `round`=10 → d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
- AES-256 key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 → `ready` at cycle 15. Then `round`=2 → 9ba35411 8e6925af a51a8b5f 2067fcde; `round`=14 → fe4890d1 e6188d0b 046df344 706c631e.
- `init` pulsed again at cycle 5 during AES-128 expansion with a different key → ignored; final keys match the first key and `ready` still rises at cycle 12.
- `reset` asserted at cycle 6 of an expansion → next cycle `ready` = 1, `round_key` = 0 for every `round`, `sboxw` = 0. A fresh `init` then gives correct keys.
- `keylen` toggled during GEN, and `round` = 15 after ready → AES-128 schedule unaffected; `round_key` = 0 for `round` = 15.
- Back-to-back: AES-256 expansion immediately followed by AES-128 `init` the cycle `ready` rises → `ready` = 0 one cycle later, 12 cycles to completion, `rk[0..10]` = AES-128 vectors.
